// File: rtl/mux_2to1_8bit_feeder.sv
// Operand registers and dwell-timed A/B select sequencer feeding mux_2to1_8bit.
// Only the operand that is not currently selected may be rewritten while running.
//
// state | meaning
// IDLE  | not alternating, sel=0, both operands writable
// RUN_A | alternating, in0 selected (sel=0), only in1 writable
// RUN_B | alternating, in1 selected (sel=1), only in0 writable
module mux_2to1_8bit_feeder #(
  parameter int WIDTH   = 8,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic               load_dest,
  input  logic [WIDTH-1:0]   load_data,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  output logic               busy,
  output logic               sel,
  output logic [WIDTH-1:0]   in0,
  output logic [WIDTH-1:0]   in1,
  output logic [7:0]         phase_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN_A = 2'd1,
    RUN_B = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  logic [DWELL_W-1:0] dwell_sh, dwell_sh_nxt;
  logic [DWELL_W-1:0] dwell_eff;
  logic [7:0]         pc_nxt;
  logic [7:0]         pc_inc;

  assign dwell_eff  = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign pc_inc     = (phase_count == 8'hFF) ? phase_count : phase_count + 8'd1;
  assign sel        = (state == RUN_B);
  assign busy       = (state != IDLE);
  assign load_ready = (state == IDLE) || (load_dest != sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dwell_sh    <= DWELL_W'(1);
      phase_count <= 8'd0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      dwell_sh    <= dwell_sh_nxt;
      phase_count <= pc_nxt;
    end
  end

  // stop wins over a phase switch falling on the same edge
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    dwell_sh_nxt = dwell_sh;
    pc_nxt       = phase_count;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nxt    = RUN_A;
          dwell_sh_nxt = dwell_eff;
          cnt_nxt      = dwell_eff - DWELL_W'(1);
          pc_nxt       = 8'd0;
        end
      end
      RUN_A, RUN_B: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          state_nxt = (state == RUN_A) ? RUN_B : RUN_A;
          cnt_nxt   = dwell_sh - DWELL_W'(1);
          pc_nxt    = pc_inc;
        end else begin
          cnt_nxt = cnt - DWELL_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in0 <= '0;
      in1 <= '0;
    end else if (load_valid && load_ready) begin
      if (load_dest) in1 <= load_data;
      else           in0 <= load_data;
    end
  end

endmodule

// File: tb/tb_mux_2to1_8bit_feeder.sv
// Directed bench for mux_2to1_8bit_feeder: expected values queued when stimulus
// is applied and popped when the design responds.
module tb_mux_2to1_8bit_feeder;

  logic       clk;
  logic       rst_n;
  logic       load_valid;
  logic       load_ready;
  logic       load_dest;
  logic [7:0] load_data;
  logic       start;
  logic       stop;
  logic [3:0] dwell;
  logic       busy;
  logic       sel;
  logic [7:0] in0;
  logic [7:0] in1;
  logic [7:0] phase_count;
  logic [7:0] mux_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic [23:0] exp_q[$];

  mux_2to1_8bit_feeder #(.WIDTH(8), .DWELL_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_dest   (load_dest),
    .load_data   (load_data),
    .start       (start),
    .stop        (stop),
    .dwell       (dwell),
    .busy        (busy),
    .sel         (sel),
    .in0         (in0),
    .in1         (in1),
    .phase_count (phase_count)
  );

  // downstream mux model
  assign mux_out = sel ? in1 : in0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_op(input logic dest, input logic [7:0] data, input string tag);
    int waited;
    logic [23:0] e;
    waited = 0;
    load_valid = 1'b1;
    load_dest  = dest;
    load_data  = data;
    #1;
    while (!load_ready && waited < 40) begin
      step();
      waited++;
    end
    chk({tag, "_ready"}, load_ready, 1);
    exp_q.push_back({16'd0, data});
    step();
    load_valid = 1'b0;
    e = exp_q.pop_front();
    chk(tag, dest ? in1 : in0, e[7:0]);
  endtask

  initial begin
    logic [23:0] e;
    rst_n = 1'b0; load_valid = 1'b0; load_dest = 1'b0; load_data = 8'h00;
    start = 1'b0; stop = 1'b0; dwell = 4'd3;

    // reset state
    #12;
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in0", in0, 0);
    chk("rst_in1", in1, 0);
    chk("rst_pc", phase_count, 0);
    chk("rst_ready", load_ready, 1);
    #5 rst_n = 1'b1;
    step();

    // idle loads
    load_op(1'b0, 8'h5F, "idle_in0");
    load_op(1'b1, 8'hC8, "idle_in1");
    chk("idle_sel", sel, 0);
    chk("idle_busy", busy, 0);

    // alternation with dwell 3
    dwell = 4'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("alt_busy", busy, 1);
    for (int k = 0; k <= 12; k++)
      exp_q.push_back({8'((k / 3) % 2), 8'(k / 3), (((k / 3) % 2) != 0) ? 8'hC8 : 8'h5F});
    for (int k = 0; k <= 12; k++) begin
      e = exp_q.pop_front();
      chk("alt_sel", sel, e[23:16]);
      chk("alt_pc", phase_count, e[15:8]);
      chk("alt_mux", mux_out, e[7:0]);
      if (k < 12) step();
    end

    // load blocking in RUN_B (k=15..17), accepted once RUN_A begins at k=18
    step(); step(); step();
    chk("blk_inrunb", sel, 1);
    load_valid = 1'b1; load_dest = 1'b1; load_data = 8'h91;
    #1;
    for (int k = 15; k < 18; k++) begin
      chk("blk_ready", load_ready, 0);
      chk("blk_in1", in1, 8'hC8);
      step();
    end
    chk("blk_sel", sel, 0);
    chk("blk_ready_a", load_ready, 1);
    chk("blk_in1_hold", in1, 8'hC8);
    exp_q.push_back({16'd0, 8'h91});
    step();
    load_valid = 1'b0;
    e = exp_q.pop_front();
    chk("blk_in1_new", in1, e[7:0]);

    // write in final cycle of RUN_A is what appears after the toggle
    step();
    chk("last_sel", sel, 0);
    load_valid = 1'b1; load_dest = 1'b1; load_data = 8'h33;
    #1;
    chk("last_ready", load_ready, 1);
    step();
    load_valid = 1'b0;
    chk("last_sel_tog", sel, 1);
    chk("last_mux", mux_out, 8'h33);

    // stop mid-phase, count holds
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_sel", sel, 0);
    chk("stop_pc", phase_count, 7);
    step();
    chk("stop_pc_hold", phase_count, 7);

    // start+stop together in IDLE
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", busy, 0);

    // dwell 0 behaves as 1; stop on a toggle edge
    dwell = 4'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k <= 4; k++)
      exp_q.push_back({8'(k % 2), 8'(k), 8'h00});
    for (int k = 0; k <= 4; k++) begin
      e = exp_q.pop_front();
      chk("d0_sel", sel, e[23:16]);
      chk("d0_pc", phase_count, e[15:8]);
      if (k < 4) step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("d0_stop_busy", busy, 0);
    chk("d0_stop_sel", sel, 0);
    chk("d0_stop_pc", phase_count, 4);

    // saturation and restart
    dwell = 4'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 254; k++) step();
    chk("sat_pc254", phase_count, 254);
    for (int k = 0; k < 46; k++) step();
    chk("sat_pc", phase_count, 255);
    chk("sat_busy", busy, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("sat_stop_pc", phase_count, 255);
    chk("sat_stop_busy", busy, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_pc", phase_count, 0);
    chk("restart_busy", busy, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // asynchronous reset in RUN_B
    load_op(1'b1, 8'h1D, "pre_rst_in1");
    dwell = 4'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("pre_rst_sel", sel, 1);
    chk("pre_rst_pc", phase_count, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sel", sel, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in0", in0, 0);
    chk("arst_in1", in1, 0);
    chk("arst_pc", phase_count, 0);
    chk("arst_ready", load_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_2to1_8bit_feeder.md
# mux_2to1_8bit_feeder

Upstream operand-and-select stage for `mux_2to1_8bit`. It holds the two 8-bit operands (`in0`, `in1`) in registers loaded over a valid/ready byte interface. It drives `sel` from a dwell-timed A/B alternation state machine, so the mux output switches between operands on a programmable schedule. While the machine runs, only the operand that is not currently selected may be overwritten, so `mux_out` never glitches mid-phase.

## Interface

Parameters:
- `WIDTH`, 8, operand width (must match `mux_2to1_8bit`)
- `DWELL_W`, 4, width of the dwell-length input

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `load_valid`  in  1  operand write request
- `load_ready`  out  1  operand write accepted this cycle when high with `load_valid`
- `load_dest`  in  1  target register: 0 → `in0`, 1 → `in1`
- `load_data`  in  WIDTH  operand value
- `start`  in  1  begin alternation (pulse)
- `stop`  in  1  end alternation (pulse)
- `dwell`  in  DWELL_W  cycles per phase; 0 treated as 1
- `busy`  out  1  high in RUN_A / RUN_B
- `sel`  out  1  to mux `sel`
- `in0`  out  WIDTH  to mux `in0`
- `in1`  out  WIDTH  to mux `in1`
- `phase_count`  out  8  completed phase transitions since last start, saturating

## Operation

- States:
  - IDLE: `sel`=0
  - RUN_A: `sel`=0
  - RUN_B: `sel`=1
- IDLE → RUN_A:
  - Condition: `start`=1 and `stop`=0.
  - Latches the effective dwell D = max(`dwell`,1) into a shadow register.
  - Loads the down-counter with D−1.
  - Clears `phase_count`.
- RUN_A/RUN_B, counter ≠ 0: decrement and stay.
- RUN_A/RUN_B, counter = 0:
  - Switch to the other RUN state and reload D−1.
  - `phase_count` +1, saturating at 255.
- Any RUN state with `stop`=1: → IDLE next cycle. `stop` has priority over a same-cycle phase switch. The count does not increment on that edge.
- `start` in a RUN state is ignored. A `dwell` change takes effect only at the next start.
- `stop` in IDLE has no effect. `start`+`stop` together in IDLE: stay IDLE.
- `load_ready` is combinational: 1 in IDLE; in RUN states, 1 iff `load_dest` ≠ `sel`.
- When `load_valid`&`load_ready`, the selected register takes `load_data` at the clock edge.
- When `load_valid`&!`load_ready`, nothing is written. The requester holds `load_valid`/`load_data` until accepted.
- Reset values:
  - state IDLE
  - `sel`=0, `busy`=0
  - `in0`=`in1`=0
  - `phase_count`=0
  - counter=0, shadow D=1
  - `load_ready`=1, following from IDLE
- Reset asserted mid-run: all registers return to the reset values immediately, asynchronously; no partial load survives.

## Timing

- Operand write: visible on `in0`/`in1` the cycle after the accepting edge. One write per cycle maximum.
- `start` sampled at edge T: `busy`=1 and `sel`=0 from T+1.
- Each phase lasts exactly D cycles.
  - `sel` toggles at edges T+D, T+2D, …
  - `phase_count` increments on the same edges.
- D=1: `sel` toggles every cycle. `load_ready` then alternates per `load_dest`.
- `stop` sampled at edge S: `busy`=0 and `sel`=0 from S+1. `phase_count` holds its value until the next start.
- A write to the non-selected operand in the final cycle of a phase is accepted. The new value is the one selected after the toggle.

## Test plan

- Reset then idle load:
  - Stimulus: release `rst_n`; load `in0`=0x5F, then `in1`=0xC8.
  - Required: `load_ready`=1 throughout; `in0`=0x5F and `in1`=0xC8 one cycle after each accept; `sel`=0, `busy`=0.
- Alternation with dwell=3, `in0`=0x5F, `in1`=0xC8:
  - Stimulus: pulse `start`.
  - Required: `sel` pattern 0,0,0,1,1,1,0…; `phase_count` reaches 4 after 12 cycles; downstream `mux_out` alternates 0x5F/0xC8 in blocks of 3.
- Load blocking:
  - Stimulus: during RUN_B, hold `load_valid` with dest=1, data 0x91.
  - Required: `load_ready`=0 and `in1` unchanged until RUN_A begins; then accepted, and `in1`=0x91 the next cycle.
- Dwell 0 and stop priority:
  - Stimulus: `dwell`=0, start; assert `stop` coincident with a toggle edge.
  - Required: `sel` toggles every cycle before the stop; after it, IDLE, `sel`=0, and `phase_count` equals the transitions strictly before the stop.
- Saturation and restart:
  - Stimulus: dwell=1 for 300 cycles, then stop and start.
  - Required: `phase_count` holds 255; it clears to 0 on restart.
- Asynchronous reset mid-run:
  - Stimulus: drop `rst_n` between clock edges in RUN_B with `in1`=0x1D.
  - Required: `sel`, `busy`, `in0`, `in1` and `phase_count` go to 0 immediately, without waiting for `clk`.
